// File: rtl/fetch_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : fetch_branch_predictor_btb
// Description : Direct-mapped branch target buffer with per-entry saturating
//               direction counters. A search returns its result one cycle
//               later through lockable output registers. Updates come from
//               execute-stage branch resolution.
//               Optional macro FETCH_BTB_GSHARE_EN indexes the counters with
//               the address index XORed with a global history register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_branch_predictor_btb #(
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 2
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iFLUSH,
  input  logic        iSEARCH_STB,
  input  logic [31:0] iSEARCH_INST_ADDR,
  input  logic        iSEARCH_LOCK,
  output logic        oSEARCH_VALID,
  output logic        oSEARCH_HIT,
  output logic        oSEARCH_PREDICT_BRANCH,
  output logic [31:0] oSEARCH_ADDR,
  input  logic        iJUMP_STB,
  input  logic        iJUMP_JUMP,
  input  logic [31:0] iJUMP_ADDR,
  input  logic [31:0] iJUMP_INST_ADDR
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Weakly taken: MSB set, every other bit clear
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  // Table storage
  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q,   tag_d;
  logic [ENTRIES-1:0][29:0]      tgt_q,   tgt_d;
  logic [ENTRIES-1:0][CNT_W-1:0] cnt_q,   cnt_d;

  // Output registers
  logic        valid_out_q, valid_out_d;
  logic        hit_out_q,   hit_out_d;
  logic        pred_out_q,  pred_out_d;
  logic [31:0] addr_out_q,  addr_out_d;

  // Indices and tags
  logic [INDEX_W-1:0] s_idx, s_cidx, u_idx, u_cidx;
  logic [TAG_W-1:0]   s_tag, u_tag;
  logic               s_hit, u_hit;

  // Word-offset bits carry no information for the predictor
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iSEARCH_INST_ADDR[1:0], iJUMP_INST_ADDR[1:0],
                              iJUMP_ADDR[1:0]};

  assign s_idx = iSEARCH_INST_ADDR[INDEX_W+1:2];
  assign s_tag = iSEARCH_INST_ADDR[31:INDEX_W+2];
  assign u_idx = iJUMP_INST_ADDR[INDEX_W+1:2];
  assign u_tag = iJUMP_INST_ADDR[31:INDEX_W+2];

  assign s_hit = valid_q[s_idx] && (tag_q[s_idx] == s_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

`ifdef FETCH_BTB_GSHARE_EN
  logic [INDEX_W-1:0] hist_q, hist_d;

  // History shifts in each resolved outcome; flush leaves it alone
  always_comb begin
    hist_d = hist_q;
    if (iJUMP_STB && !iFLUSH) begin
      hist_d = INDEX_W'({hist_q, iJUMP_JUMP});
    end
  end

  // History register, cleared only by reset
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Both ports use the pre-shift history for the counter index
  assign s_cidx = s_idx ^ hist_q;
  assign u_cidx = u_idx ^ hist_q;
`else
  assign s_cidx = s_idx;
  assign u_cidx = u_idx;
`endif

  // Table next state: flush wins over a same-cycle update
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (iFLUSH) begin
      valid_d = '0;
    end else if (iJUMP_STB) begin
      if (u_hit) begin
        if (iJUMP_JUMP) begin
          if (cnt_q[u_cidx] != CNT_MAX) begin
            cnt_d[u_cidx] = cnt_q[u_cidx] + CNT_W'(1);
          end
          tgt_d[u_idx] = iJUMP_ADDR[31:2];
        end else if (cnt_q[u_cidx] != '0) begin
          cnt_d[u_cidx] = cnt_q[u_cidx] - CNT_W'(1);
        end
      end else if (iJUMP_JUMP) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = iJUMP_ADDR[31:2];
        cnt_d[u_cidx]  = CNT_WEAK;
      end
    end
  end

  // Search result: reads pre-update contents; flush forces a miss; lock holds
  always_comb begin
    valid_out_d = valid_out_q;
    hit_out_d   = hit_out_q;
    pred_out_d  = pred_out_q;
    addr_out_d  = addr_out_q;
    if (!iSEARCH_LOCK) begin
      valid_out_d = iSEARCH_STB;
      hit_out_d   = s_hit && !iFLUSH;
      pred_out_d  = s_hit && !iFLUSH && cnt_q[s_cidx][CNT_W-1];
      addr_out_d  = {tgt_q[s_idx], 2'b00};
    end
  end

  // State registers; reset overrides everything else
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      valid_q     <= '0;
      tag_q       <= '0;
      tgt_q       <= '0;
      cnt_q       <= '0;
      valid_out_q <= 1'b0;
      hit_out_q   <= 1'b0;
      pred_out_q  <= 1'b0;
      addr_out_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      valid_out_q <= valid_out_d;
      hit_out_q   <= hit_out_d;
      pred_out_q  <= pred_out_d;
      addr_out_q  <= addr_out_d;
    end
  end

  assign oSEARCH_VALID          = valid_out_q;
  assign oSEARCH_HIT            = hit_out_q;
  assign oSEARCH_PREDICT_BRANCH = pred_out_q;
  assign oSEARCH_ADDR           = addr_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_branch_predictor_btb
// Description : Directed, table-driven bench for fetch_branch_predictor_btb
//               (INDEX_W = 3, CNT_W = 2, FETCH_BTB_GSHARE_EN undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst, flush, stb, lock, jstb, jj;
  logic [31:0] saddr, jaddr, jinst;
  logic        o_valid, o_hit, o_pred;
  logic [31:0] o_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_branch_predictor_btb #(.INDEX_W(3), .CNT_W(2)) dut (
    .iCLOCK                 (clk),
    .iRESET_SYNC            (rst),
    .iFLUSH                 (flush),
    .iSEARCH_STB            (stb),
    .iSEARCH_INST_ADDR      (saddr),
    .iSEARCH_LOCK           (lock),
    .oSEARCH_VALID          (o_valid),
    .oSEARCH_HIT            (o_hit),
    .oSEARCH_PREDICT_BRANCH (o_pred),
    .oSEARCH_ADDR           (o_addr),
    .iJUMP_STB              (jstb),
    .iJUMP_JUMP             (jj),
    .iJUMP_ADDR             (jaddr),
    .iJUMP_INST_ADDR        (jinst)
  );

  typedef struct {
    logic        rst, flush, lock, stb;
    logic [31:0] sa;
    logic        jstb, jj;
    logic [31:0] ji, jt;
    logic        ev;      // expected valid (always checked)
    logic        ch;      // check hit/predict
    logic        eh, ep;
    logic        ca;      // check address
    logic [31:0] ea;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, f, l, s, input logic [31:0] sa,
                              input logic js, j, input logic [31:0] ji, jt,
                              input logic ev, ch, eh, ep, ca,
                              input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.flush = f; v.lock = l; v.stb = s; v.sa = sa;
    v.jstb = js; v.jj = j; v.ji = ji; v.jt = jt;
    v.ev = ev; v.ch = ch; v.eh = eh; v.ep = ep; v.ca = ca; v.ea = ea;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.flush; lock = v.lock; stb = v.stb; saddr = v.sa;
    jstb = v.jstb; jj = v.jj; jinst = v.ji; jaddr = v.jt;
  endtask

  task automatic check(input int idx, input vec_t v);
    logic bad;
    bad = (o_valid !== v.ev);
    if (v.ch && ((o_hit !== v.eh) || (o_pred !== v.ep))) bad = 1'b1;
    if (v.ca && (o_addr !== v.ea)) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL vec%0d: got valid=%b hit=%b pred=%b addr=%h, want valid=%b hit=%b pred=%b addr=%h (hit chk %b, addr chk %b)",
               idx, o_valid, o_hit, o_pred, o_addr, v.ev, v.eh, v.ep, v.ea,
               v.ch, v.ca);
    end
  endtask

  localparam logic [31:0] A40 = 32'h40, A60 = 32'h60, A80 = 32'h80;
  localparam logic [31:0] T1 = 32'h1000, T2 = 32'h2000, T3 = 32'h3000;

  initial begin
    vec_t idle;
    // ---- table: one row per clock, outputs checked after that edge ----
    //                 rst f l s sa   js j ji   jt   ev ch eh ep ca ea
    vq.push_back(mk(1, 0, 0, 1, A40, 1, 1, A40, T1, 0, 1, 0, 0, 1, 0));  // 0 reset overrides
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 0, 0, 0, 0));  // 1 cold miss
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, A40, T1, 0, 0, 0, 0, 0, 0));  // 2 alloc -> 10
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 1, 1, T1)); // 3 hit taken
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, A40, 0,  0, 0, 0, 0, 0, 0));  // 4 -> 01
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, A40, 0,  0, 0, 0, 0, 0, 0));  // 5 -> 00
    vq.push_back(mk(0, 0, 0, 1, A40, 1, 0, A40, 0,  1, 1, 1, 0, 1, T1)); // 6 hit nt, stays 00
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 0, 1, T1)); // 7 still 00
    for (int i = 0; i < 4; i++)                                           // 8-11 -> 11 sat
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, A40, T1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, A40, 0,  0, 0, 0, 0, 0, 0));  // 12 -> 10
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 1, 1, T1)); // 13 predict
    vq.push_back(mk(0, 0, 0, 1, A40, 1, 0, A40, 0,  1, 1, 1, 1, 1, T1)); // 14 read-old, ->01
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 0, 1, T1)); // 15 sees 01
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, A40, T1, 0, 0, 0, 0, 0, 0));  // 16 -> 10
    vq.push_back(mk(0, 0, 0, 1, A60, 0, 0, 0,   0,  1, 1, 0, 0, 0, 0));  // 17 tag miss
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, A60, 0,  0, 0, 0, 0, 0, 0));  // 18 nt miss: no-op
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 1, 1, T1)); // 19 intact
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, A60, T2, 0, 0, 0, 0, 0, 0));  // 20 evict
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 0, 0, 0, 0));  // 21 evicted
    vq.push_back(mk(0, 0, 0, 1, A60, 0, 0, 0,   0,  1, 1, 1, 1, 1, T2)); // 22 new owner
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, A40, T1, 0, 0, 0, 0, 0, 0));  // 23 realloc 0x40
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 1, 1, T1)); // 24 hit
    vq.push_back(mk(0, 0, 1, 1, A80, 0, 0, 0,   0,  1, 1, 1, 1, 1, T1)); // 25 lock holds
    vq.push_back(mk(0, 0, 1, 0, 0,   1, 0, A40, 0,  1, 1, 1, 1, 1, T1)); // 26 hold, upd ->01
    vq.push_back(mk(0, 0, 0, 1, A80, 0, 0, 0,   0,  1, 1, 0, 0, 0, 0));  // 27 unlock miss
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 0, 1, T1)); // 28 locked upd done
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, A40, T1, 0, 0, 0, 0, 0, 0));  // 29 -> 10
    vq.push_back(mk(0, 1, 0, 1, A40, 1, 1, A80, T3, 1, 1, 0, 0, 0, 0));  // 30 flush
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 0, 0, 0, 0));  // 31 flushed
    vq.push_back(mk(0, 0, 0, 1, A80, 0, 0, 0,   0,  1, 1, 0, 0, 0, 0));  // 32 upd discarded
    vq.push_back(mk(0, 1, 0, 0, 0,   0, 0, 0,   0,  0, 1, 0, 0, 0, 0));  // 33 flush, no stb
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, A40, T1, 0, 0, 0, 0, 0, 0));  // 34 alloc
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 1, 1, 1, T1)); // 35 hit
    vq.push_back(mk(1, 0, 1, 1, A40, 0, 0, 0,   0,  0, 1, 0, 0, 1, 0));  // 36 reset beats lock
    vq.push_back(mk(0, 0, 0, 1, A40, 0, 0, 0,   0,  1, 1, 0, 0, 0, 0));  // 37 table cleared

    // ---- hand sequence: hold reset over several edges, outputs stay 0 ----
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    @(negedge clk);
    drive(idle);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check(-1 - i, idle);
      @(negedge clk);
    end

    // ---- table replay ----
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1 check(i, vq[i]);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_branch_predictor_btb.md
Name: fetch_branch_predictor_btb

Overview:
- Parametrised successor to the fetch-stage branch predictor.
- Direct-mapped branch target buffer (BTB) with per-entry N-bit saturating direction counters. Depth and counter width are configurable.
- Search path is registered with a lock/hold; update path comes from execute-stage jump resolution.
- Sits between fetch address generation and the fetch queue; supplies predicted-taken and target one cycle after a search strobe.

Parameters:
- INDEX_W, 3, log2 of entry count (8 entries); index = addr[INDEX_W+1:2], tag = addr[31:INDEX_W+2].
- CNT_W, 2, direction counter width; predict taken when counter MSB = 1.

Ports:
- iCLOCK  in  1  clock; all logic on rising edge.
- iRESET_SYNC  in  1  synchronous, active-high reset.
- iFLUSH  in  1  invalidate all BTB entries.
- iSEARCH_STB  in  1  search request.
- iSEARCH_INST_ADDR  in  32  fetch address to look up.
- iSEARCH_LOCK  in  1  hold output registers.
- oSEARCH_VALID  out  1  registered search strobe.
- oSEARCH_HIT  out  1  registered tag hit.
- oSEARCH_PREDICT_BRANCH  out  1  registered hit AND counter MSB.
- oSEARCH_ADDR  out  32  registered predicted target.
- iJUMP_STB  in  1  branch resolution strobe.
- iJUMP_JUMP  in  1  branch actually taken.
- iJUMP_ADDR  in  32  resolved target.
- iJUMP_INST_ADDR  in  32  address of the resolved branch.

Behaviour:
- Reset: while iRESET_SYNC = 1, all valid bits, counters and tags are cleared. All outputs are 0 on the cycle after the asserting edge. Reset overrides flush, update, search and lock.
- Search latency: 1 cycle. At the edge where iSEARCH_STB = 1 and iSEARCH_LOCK = 0, the output registers load:
  - valid = 1
  - hit = entry valid AND tag match
  - predict = hit AND cnt[CNT_W-1]
  - addr = stored target
- A search on a miss still returns valid = 1, hit = 0, predict = 0, and addr = stored target (don't-care).
- iSEARCH_STB = 0 with lock = 0: valid loads 0; the other outputs load the lookup value and are don't-care.
- Lock: iSEARCH_LOCK = 1 holds all four output registers. Table updates and flush still proceed.
- Update, when iJUMP_STB = 1 and iFLUSH = 0:
  - Hit, taken: counter = min(cnt+1, 2^CNT_W-1); target = iJUMP_ADDR.
  - Hit, not taken: counter = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate (overwrite). Valid = 1, tag written, target = iJUMP_ADDR, counter = weakly taken (MSB = 1, other bits 0; 2'b10 for CNT_W = 2).
  - Miss, not taken: no change.
- Same-cycle search and update to the same index: the search reads pre-update contents (read-old). The new contents are visible to a search issued on the next cycle.
- Flush: iFLUSH = 1 clears all valid bits at that edge.
  - A same-cycle update is discarded.
  - A same-cycle search (lock = 0) returns valid = iSEARCH_STB, hit = 0, predict = 0.
- The table is flop-based (no SRAM), with 2^INDEX_W entries of {valid, tag, target[31:2], cnt}. Target bits [1:0] always read as 00.

Optional Feature:
- Macro: FETCH_BTB_GSHARE_EN.
- Defined:
  - Adds an INDEX_W-bit global history register, cleared by reset and not by flush.
  - On each iJUMP_STB (flush = 0), the register shifts left with iJUMP_JUMP entering bit 0.
  - Counter index for both search and update = addr[INDEX_W+1:2] XOR history, using the history value before that cycle's shift.
  - Target, tag and valid remain indexed by addr[INDEX_W+1:2]. Counters are therefore a separate 2^INDEX_W array.
- Undefined: no history register; the counter shares the plain address index. Port list is identical either way.

Test Plan (INDEX_W = 3, CNT_W = 2, macro undefined):
- Reset, then search 0x40 -> next cycle valid = 1, hit = 0, predict = 0; all outputs were 0 during reset.
- Update inst 0x40, jump = 1, target 0x1000; then search 0x40 -> valid = 1, hit = 1, predict = 1, addr = 0x00001000.
- Two not-taken updates on 0x40, then search -> hit = 1, predict = 0 (counter 00). A third not-taken keeps counter at 00. Three taken updates -> counter 11; one not-taken then gives 10 and predict = 1.
- After training 0x40, search 0x60 (same index, different tag) -> hit = 0. Not-taken update on 0x60 leaves the 0x40 entry intact. Taken update 0x60 -> 0x2000 evicts it, and search 0x40 then misses.
- Lock: search 0x40 (hit) with lock raised the next cycle, plus a search of 0x80 during lock -> outputs stay addr 0x1000, predict = 1 until lock drops. The first unlocked search then updates the outputs.
- Flush with simultaneous taken update 0x80 and search 0x40 -> outputs valid = 1, hit = 0. Subsequent searches of 0x40 and 0x80 both miss.
